// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU operand issue / result capture controller with local register file
// Optional op_count output under macro ALU_ISSUE_CNT_EN.
module alu_issue #(
    parameter int REG_N = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_form,
    input  logic [1:0]       cmd_vec,
    input  logic [3:0]       cmd_copy_select,
    input  logic [IDX_W-1:0] cmd_src_a,
    input  logic [IDX_W-1:0] cmd_src_b,
    input  logic [IDX_W-1:0] cmd_src_c,
    input  logic [IDX_W-1:0] cmd_src_d,
    input  logic [IDX_W-1:0] cmd_dst1,
    input  logic [IDX_W-1:0] cmd_dst2,
    input  logic [1:0]       cmd_wr_mask,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_addr,
    input  logic [31:0]      ld_data,
    output logic [2:0]       alu_op,
    output logic             alu_form,
    output logic [1:0]       alu_vec,
    output logic [3:0]       alu_copy_select,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [31:0]      alu_c,
    output logic [31:0]      alu_d,
    input  logic [31:0]      alu_y1,
    input  logic [31:0]      alu_y2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_y1,
    output logic [31:0]      res_y2,
    output logic             busy
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               form_q, form_d;
    logic [1:0]         vec_q, vec_d;
    logic [3:0]         cs_q, cs_d;
    logic [31:0]        a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [IDX_W-1:0]   dst1_q, dst1_d, dst2_q, dst2_d;
    logic [1:0]         mask_q, mask_d;
    logic [31:0]        y1_q, y1_d, y2_q, y2_d;
    logic [31:0]        regs_q [REG_N];
    logic [31:0]        regs_d [REG_N];
    logic               accept;

    // Indices with no matching entry (>= REG_N) read as zero.
    function automatic logic [31:0] rd(input logic [IDX_W-1:0] idx);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < REG_N; i++) begin
            if (idx == IDX_W'(i)) v = regs_q[i];
        end
        return v;
    endfunction

    assign accept = cmd_valid && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        res_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        op_d   = op_q;   form_d = form_q; vec_d  = vec_q;  cs_d   = cs_q;
        a_d    = a_q;    b_d    = b_q;    c_d    = c_q;    d_d    = d_q;
        dst1_d = dst1_q; dst2_d = dst2_q; mask_d = mask_q;
        y1_d   = y1_q;   y2_d   = y2_q;
        if (accept) begin
            op_d   = cmd_op;   form_d = cmd_form; vec_d = cmd_vec; cs_d = cmd_copy_select;
            a_d    = rd(cmd_src_a); b_d = rd(cmd_src_b);
            c_d    = rd(cmd_src_c); d_d = rd(cmd_src_d);
            dst1_d = cmd_dst1; dst2_d = cmd_dst2; mask_d = cmd_wr_mask;
        end
        if (state_q == CAPTURE) begin
            y1_d = alu_y1;
            y2_d = alu_y2;
        end
    end

    // Later assignments win: external load, then Y1, then Y2 writeback.
    always_comb begin
        for (int i = 0; i < REG_N; i++) begin
            regs_d[i] = regs_q[i];
            if (ld_en && ld_addr == IDX_W'(i)) regs_d[i] = ld_data;
            if (state_q == CAPTURE && mask_q[0] && dst1_q == IDX_W'(i)) regs_d[i] = alu_y1;
            if (state_q == CAPTURE && mask_q[1] && dst2_q == IDX_W'(i)) regs_d[i] = alu_y2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0; form_q <= 1'b0; vec_q <= '0; cs_q <= '0;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
            dst1_q <= '0; dst2_q <= '0; mask_q <= '0;
            y1_q <= '0; y2_q <= '0;
            for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
        end else begin
            op_q <= op_d; form_q <= form_d; vec_q <= vec_d; cs_q <= cs_d;
            a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
            dst1_q <= dst1_d; dst2_q <= dst2_d; mask_q <= mask_d;
            y1_q <= y1_d; y2_q <= y2_d;
            for (int i = 0; i < REG_N; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign alu_op          = op_q;
    assign alu_form        = form_q;
    assign alu_vec         = vec_q;
    assign alu_copy_select = cs_q;
    assign alu_a           = a_q;
    assign alu_b           = b_q;
    assign alu_c           = c_q;
    assign alu_d           = d_q;
    assign res_y1          = y1_q;
    assign res_y2          = y2_q;

`ifdef ALU_ISSUE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == RESP && res_ready) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign op_count = cnt_q;
`endif

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts compact commands (opcode plus register indices) over a valid/ready handshake and reads four operands from an internal register file.
- Drives registered operands and control into the combinational ALU, captures Y1/Y2 one cycle later, and writes them back to the register file.
- Presents the result on a valid/ready output handshake.
- Sits between the sequencer/decoder and the ALU.

Parameters:
- REG_N, 8, number of 32-bit registers in the local register file.
- IDX_W, 3, register index width; must equal ceil(log2(REG_N)).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  ALU op code
- cmd_form  in  1  ALU form select
- cmd_vec  in  2  ALU vector mode
- cmd_copy_select  in  4  ALU copy select
- cmd_src_a, cmd_src_b, cmd_src_c, cmd_src_d  in  IDX_W each  operand register indices
- cmd_dst1, cmd_dst2  in  IDX_W each  writeback indices for Y1, Y2
- cmd_wr_mask  in  2  bit0 enables Y1 writeback, bit1 enables Y2 writeback
- ld_en  in  1  external register load strobe
- ld_addr  in  IDX_W  external load index
- ld_data  in  32  external load data
- alu_op, alu_form, alu_vec, alu_copy_select  out  3/1/2/4  registered ALU controls
- alu_a, alu_b, alu_c, alu_d  out  32 each  registered ALU operands
- alu_y1, alu_y2  in  32 each  ALU results (combinational)
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready
- res_y1, res_y2  out  32 each  captured results
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; cmd_ready=1; res_valid=0; busy=0; all alu_* outputs 0; res_y1=res_y2=0; all registers 0.
- FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On handshake, load alu_* controls from cmd_* and alu_a..d from regfile[cmd_src_*].
  - Operand reads see register contents before this edge; an ld_en write on the same edge is not visible.
  - Go to ISSUE.
- ISSUE:
  - One cycle; the ALU settles on stable inputs.
  - alu_* outputs hold their values until the next accepted command. They are not cleared.
  - Go to CAPTURE.
- CAPTURE:
  - Sample alu_y1/alu_y2 into res_y1/res_y2.
  - Write Y1 to regfile[cmd_dst1] if mask bit0 is set; write Y2 to regfile[cmd_dst2] if mask bit1 is set. dst/mask are latched at acceptance.
  - If dst1==dst2 and both mask bits are set, Y2 wins.
  - Go to RESP.
- RESP:
  - res_valid=1.
  - res_y1/res_y2 stay stable while res_valid=1 and res_ready=0.
  - On res_ready: res_valid drops next cycle and the state returns to IDLE.
- Latency: command handshake edge to res_valid=1 is 3 cycles.
- Throughput: one command per 4 cycles when res_ready is held high.
- cmd_ready is 0 in ISSUE, CAPTURE and RESP. No commands are queued.
- ld_en:
  - Applies in any state.
  - If it targets the same address as a CAPTURE writeback on the same edge, the writeback wins.
  - An ld_en on the ISSUE edge does not affect operands already driven.
- cmd_wr_mask=0: no regfile change; the result is still reported.
- Reset mid-operation (any state): immediate return to reset values. The pending result is discarded and the regfile is cleared.
- Index inputs ≥ REG_N (only possible when REG_N is not a power of two): reads return 0; writes are ignored.

Optional Feature:
- Macro: ALU_ISSUE_CNT_EN.
- Defined:
  - Adds output port op_count (16 bits), reset to 0.
  - Increments on each RESP-state res_valid & res_ready handshake.
  - Wraps 0xFFFF -> 0x0000.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Load r0=1, r1=2, r2=3, r3=2. Command op=0, form=0, vec=2, src a/b/c/d=r0/r1/r2/r3, dst1=r4, dst2=r5, mask=3, res_ready=1 -> res_valid 3 cycles after acceptance, res_y1=4, res_y2=4, r4=4, r5=4.
- Same operands with form=1 -> {res_y1,res_y2}=64'd6 (res_y1=0, res_y2=6).
- Same operands with op=4, form=0 -> res_y1=32'hFFFFFFFE, res_y2=0. Second command reading r4 as operand A returns 0xFFFFFFFE (writeback visible).
- Hold res_ready=0 for 5 cycles in RESP -> res_valid stays 1, results stable, cmd_ready=0. A cmd_valid pulse during this time is not accepted. Release -> IDLE next cycle.
- ld_en to r4 with data 0xAAAA5555 on the CAPTURE edge with dst1=r4, mask=1 -> r4 holds Y1, not 0xAAAA5555.
- Assert rst_n=0 during ISSUE -> outputs and registers return to 0 asynchronously, no res_valid. With ALU_ISSUE_CNT_EN, op_count=0 after reset and 2 after two completed commands.
